// File: rtl/systolic_sequencer.sv
// systolic_sequencer: steps one tile through the attached systolic_array.
// The sequence is clear, operand load window, drain, copy to out queue, readout.
// All outputs are flops, decoded from the next state, so nothing combinational
// reaches a port from an input.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for start; busy low
// S_CLEAR      | restart array inputs and zero the accumulators (1 cycle)
// S_LOAD       | k_len*SLICES operand beats, one consumed every cycle
// S_DRAIN      | final next->curr flush plus SLICES MAC/shift cycles
// S_COPY       | copy accumulators into the out queue and restart it (1 cycle)
// S_READ       | ACC result bytes, one per cycle; out_last on the final one
// S_DONE       | one-cycle done pulse
// S_CLEAR_ABRT | abort cleanup: same array strobes as S_CLEAR, then idle
module systolic_sequencer #(
   parameter int SLICES = 4,
   parameter int KW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [KW-1:0] k_len,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          restart_inputs,
   output logic          reset_accumulators,
   output logic          copy_to_out_queue,
   output logic          restart_out_queue,
   output logic          out_valid,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          underrun
);

   localparam int ACC      = 2 * SLICES * SLICES;
   localparam int LOAD_MAX = ((1 << KW) - 1) * SLICES;
   localparam int CNT_MAX  = (LOAD_MAX > ACC) ? LOAD_MAX : ACC;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SLICES_C  = CW'(SLICES);
   localparam logic [CW-1:0] ACC_LAST  = CW'(ACC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DRAIN,
      S_COPY,
      S_READ,
      S_DONE,
      S_CLEAR_ABRT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [KW-1:0]   k_len_q;
   logic [CW-1:0]   load_last;
   logic            accept;
   logic            underrun_d;
   logic            in_ready_d, restart_inputs_d, reset_accumulators_d;
   logic            copy_to_out_queue_d, restart_out_queue_d;
   logic            out_valid_d, out_last_d, busy_d, done_d;

   // an abort in the same cycle as start wins, so the tile never begins
   assign accept    = (state_q == S_IDLE) && start && !abort;
   assign load_last = (CW'(k_len_q) * SLICES_C) - CW'(1);

   // next-state and terminal-count logic for the down-counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            if (k_len_q != '0) begin
               state_d = S_LOAD;
               cnt_d   = load_last;
            end else begin
               state_d = S_COPY;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (cnt_q == '0) begin
               state_d = S_DRAIN;
               cnt_d   = SLICES_C;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_COPY;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_COPY: begin
            state_d = S_READ;
            cnt_d   = ACC_LAST;
         end
         S_READ: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_CLEAR_ABRT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_CLEAR_ABRT;
         cnt_d   = '0;
      end
   end

   // output decode from the upcoming state so every port comes straight off a flop
   always_comb begin
      in_ready_d           = 1'b0;
      restart_inputs_d     = 1'b0;
      reset_accumulators_d = 1'b0;
      copy_to_out_queue_d  = 1'b0;
      restart_out_queue_d  = 1'b0;
      out_valid_d          = 1'b0;
      out_last_d           = 1'b0;
      done_d               = 1'b0;
      busy_d               = (state_d != S_IDLE);
      case (state_d)
         S_CLEAR, S_CLEAR_ABRT: begin
            restart_inputs_d     = 1'b1;
            reset_accumulators_d = 1'b1;
         end
         S_LOAD: in_ready_d = 1'b1;
         S_COPY: begin
            copy_to_out_queue_d = 1'b1;
            restart_out_queue_d = 1'b1;
         end
         S_READ: begin
            out_valid_d = 1'b1;
            out_last_d  = (cnt_d == '0);
         end
         S_DONE: done_d = 1'b1;
         default: ;
      endcase
      // a starved load beat does not stall the array, it only gets flagged
      if (accept) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun | ((state_q == S_LOAD) && !in_valid);
      end
   end

   // state, counter, latched k_len and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= S_IDLE;
         cnt_q              <= '0;
         k_len_q            <= '0;
         in_ready           <= 1'b0;
         restart_inputs     <= 1'b0;
         reset_accumulators <= 1'b0;
         copy_to_out_queue  <= 1'b0;
         restart_out_queue  <= 1'b0;
         out_valid          <= 1'b0;
         out_last           <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         underrun           <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         if (accept) begin
            k_len_q <= k_len;
         end
         in_ready           <= in_ready_d;
         restart_inputs     <= restart_inputs_d;
         reset_accumulators <= reset_accumulators_d;
         copy_to_out_queue  <= copy_to_out_queue_d;
         restart_out_queue  <= restart_out_queue_d;
         out_valid          <= out_valid_d;
         out_last           <= out_last_d;
         busy               <= busy_d;
         done               <= done_d;
         underrun           <= underrun_d;
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: per-cycle expected control strobes for each
// tile are queued when the start is driven and popped as the cycles go by.
module tb_systolic_sequencer;

   localparam int SLICES = 4;
   localparam int KW     = 8;
   localparam int ACC    = 2 * SLICES * SLICES;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [KW-1:0] k_len;
   logic          in_valid;
   logic          in_ready;
   logic          restart_inputs;
   logic          reset_accumulators;
   logic          copy_to_out_queue;
   logic          restart_out_queue;
   logic          out_valid;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          underrun;

   int n_assert = 0;
   int n_fail   = 0;
   logic exp_under = 1'b0;

   typedef struct packed {
      logic [8:0] vec;
      logic       under;
   } exp_t;

   exp_t sb_q[$];

   logic [8:0] obs_vec;
   assign obs_vec = {in_ready, restart_inputs, reset_accumulators, copy_to_out_queue,
                     restart_out_queue, out_valid, out_last, busy, done};

   systolic_sequencer #(.SLICES(SLICES), .KW(KW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .abort              (abort),
      .k_len              (k_len),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .restart_inputs     (restart_inputs),
      .reset_accumulators (reset_accumulators),
      .copy_to_out_queue  (copy_to_out_queue),
      .restart_out_queue  (restart_out_queue),
      .out_valid          (out_valid),
      .out_last           (out_last),
      .busy               (busy),
      .done               (done),
      .underrun           (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bit order: in_ready restart reset_acc copy restart_oq out_valid out_last busy done
   function automatic logic [8:0] exp_vec(int t, int k, int a);
      int ld = k * SLICES;
      int c  = (k == 0) ? 2 : (2 + ld + SLICES + 1);
      if (a > 0 && t == a + 1) return 9'b0_1_1_0_0_0_0_1_0;
      if (a > 0 && t > a + 1)  return 9'b0;
      if (t == 1)                                  return 9'b0_1_1_0_0_0_0_1_0;
      if (k > 0 && t >= 2 && t <= 1 + ld)          return 9'b1_0_0_0_0_0_0_1_0;
      if (k > 0 && t >= 2 + ld && t < c)           return 9'b0_0_0_0_0_0_0_1_0;
      if (t == c)                                  return 9'b0_0_0_1_1_0_0_1_0;
      if (t > c && t < c + ACC)                    return 9'b0_0_0_0_0_1_0_1_0;
      if (t == c + ACC)                            return 9'b0_0_0_0_0_1_1_1_0;
      if (t == c + ACC + 1)                        return 9'b0_0_0_0_0_0_0_1_1;
      return 9'b0;
   endfunction

   task automatic chk_vec(string tag, int t, logic [8:0] e);
      n_assert++;
      assert (obs_vec === e) else begin
         n_fail++;
         $error("FAIL %s t=%0d strobes observed=%b expected=%b", tag, t, obs_vec, e);
      end
   endtask

   task automatic chk_under(string tag, int t, logic e);
      n_assert++;
      assert (underrun === e) else begin
         n_fail++;
         $error("FAIL %s t=%0d underrun observed=%b expected=%b", tag, t, underrun, e);
      end
   endtask

   // drop: LOAD-window cycle with in_valid low; abort_at/rst_at: cycle of abort/reset;
   // p1/p2: cycles carrying a start pulse that must be ignored. 0 means unused.
   task automatic run_tile(string tag, int k, int drop, int abort_at, int p1, int p2, int rst_at);
      int   ld = k * SLICES;
      int   c  = (k == 0) ? 2 : (2 + ld + SLICES + 1);
      int   end_t;
      logic u;
      exp_t e;
      end_t = (abort_at > 0) ? abort_at + 1 : ((rst_at > 0) ? rst_at : c + ACC + 1);

      @(posedge clk); #1;
      chk_vec({tag, "_idle"}, 0, 9'b0);
      chk_under({tag, "_idle"}, 0, exp_under);
      start    = 1'b1;
      abort    = 1'b0;
      k_len    = KW'(k);
      in_valid = 1'b1;

      u = 1'b0;
      for (int t = 1; t <= end_t; t++) begin
         if (t >= 2) u = u | (exp_vec(t - 1, k, abort_at)[8] && (t - 1 == drop));
         e.vec   = exp_vec(t, k, abort_at);
         e.under = u;
         sb_q.push_back(e);
      end

      for (int t = 1; t <= end_t; t++) begin
         @(posedge clk); #1;
         if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty at t=%0d", tag, t);
         end else begin
            e = sb_q.pop_front();
            chk_vec(tag, t, e.vec);
            chk_under(tag, t, e.under);
         end
         start    = (t == p1 || t == p2);
         k_len    = 8'hA5;
         in_valid = (t != drop);
         abort    = (t == abort_at);
         if (t == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_vec({tag, "_async_rst"}, t, 9'b0);
            chk_under({tag, "_async_rst"}, t, 1'b0);
            #2;
            rst_n = 1'b1;
         end
      end

      if (rst_at > 0) exp_under = 1'b0;
      else exp_under = u | (exp_vec(end_t, k, abort_at)[8] && (end_t == drop));
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      k_len    = '0;
      in_valid = 1'b1;
      #1;
      chk_vec("reset", 0, 9'b0);
      chk_under("reset", 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk_vec("reset_hold", 0, 9'b0);
      rst_n = 1'b1;

      run_tile("k3_full",     3, 0, 0, 0, 0, 0);
      run_tile("k0_zeros",    0, 0, 0, 0, 0, 0);
      run_tile("k2_underrun", 2, 5, 0, 0, 0, 0);
      run_tile("k3_abort",    3, 0, 8, 0, 0, 0);
      run_tile("k1_after_ab", 1, 0, 0, 0, 0, 0);
      run_tile("k2_restart",  2, 0, 0, 4, 2 + 2 * SLICES + SLICES + 1 + ACC + 1, 0);
      run_tile("k1_b2b",      1, 0, 0, 0, 0, 0);
      run_tile("k1_rst_read", 1, 0, 0, 0, 0, 20);
      run_tile("k1_after_rst",1, 0, 0, 0, 0, 0);

      // start together with abort in IDLE must not begin a tile
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      k_len = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk_vec("start_abort_idle", 1, 9'b0);
      @(posedge clk); #1;
      chk_vec("start_abort_idle", 2, 9'b0);

      run_tile("k255_max",  (1 << KW) - 1, 0, 0, 0, 0, 0);
      run_tile("k1_final",  1, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
